// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
// Bit-serial add/subtract sequencer driving an external full-adder cell.
// Operands are loaded into shift registers, then one bit pair per clock is
// presented to the cell (LSB first) while its Sum/Carry are collected.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. A producer holds valid and its data stable until that edge. The
// block never raises IN_READY and OUT_VALID together, so a result handoff
// and an operand load never share an edge.
//
// Ports
//   CLK, RST           clock, synchronous active-high reset
//   IN_VALID/IN_READY  operand handshake (A_IN, B_IN, CIN, SUB)
//   FA_A/FA_B/FA_C     bit pair and carry to the full-adder cell
//   FA_SUM/FA_CARRY    cell outputs, sampled every SHIFT edge
//   OUT_VALID/OUT_READY result handshake (SUM_OUT, COUT, OVF)
//   dbg_state          current FSM state (0 idle, 1 shift, 2 done)
module serial_adder_ctrl #(
  parameter int N = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic [N-1:0] A_IN,
  input  logic [N-1:0] B_IN,
  input  logic         CIN,
  input  logic         SUB,
  output logic         FA_A,
  output logic         FA_B,
  output logic         FA_C,
  input  logic         FA_SUM,
  input  logic         FA_CARRY,
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic [N-1:0] SUM_OUT,
  output logic         COUT,
  output logic         OVF,
  output logic [1:0]   dbg_state
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [N-1:0]  a_sr;
  logic [N-1:0]  b_sr;
  // Only N-1 collected bits are kept: the final Sum bit goes straight into
  // the result register on the MSB edge.
  logic [N-2:0]  sum_sr;
  logic [N-1:0]  sum_cat;
  logic          carry_reg;
  logic [N-1:0]  sum_out_r;
  logic          cout_r;
  logic          ovf_r;
  logic          shifting;

  assign sum_cat  = {FA_SUM, sum_sr};
  assign shifting = (state == S_SHIFT);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      cnt       <= '0;
      a_sr      <= '0;
      b_sr      <= '0;
      sum_sr    <= '0;
      carry_reg <= 1'b0;
      sum_out_r <= '0;
      cout_r    <= 1'b0;
      ovf_r     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (IN_VALID) begin
            a_sr      <= A_IN;
            // Subtract as A + ~B + 1.
            b_sr      <= SUB ? ~B_IN : B_IN;
            carry_reg <= SUB ? 1'b1 : CIN;
            cnt       <= '0;
            state     <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          sum_sr    <= sum_cat[N-1:1];
          carry_reg <= FA_CARRY;
          a_sr      <= a_sr >> 1;
          b_sr      <= b_sr >> 1;
          if (cnt == CNT_LAST) begin
            cnt       <= '0;
            sum_out_r <= sum_cat;
            cout_r    <= FA_CARRY;
            // Overflow: carry into the MSB differs from carry out of it.
            ovf_r     <= carry_reg ^ FA_CARRY;
            state     <= S_DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DONE: begin
          if (OUT_READY) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Cell inputs come from registers only, gated to zero outside SHIFT.
  assign FA_A      = shifting & a_sr[0];
  assign FA_B      = shifting & b_sr[0];
  assign FA_C      = shifting & carry_reg;

  assign IN_READY  = (state == S_IDLE);
  assign OUT_VALID = (state == S_DONE);
  assign SUM_OUT   = sum_out_r;
  assign COUT      = cout_r;
  assign OVF       = ovf_r;
  assign dbg_state = state;

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial add/subtract sequencer that sits directly upstream of the reversible full-adder cell.
- Accepts two N-bit operands over a valid/ready handshake and presents one bit pair per clock to the cell's A/B/carry-in, LSB first.
- Captures the cell's Sum/Carry each clock, holding carry in a register between bits.
- Returns the N-bit result plus carry-out and signed overflow over a second valid/ready handshake.

Parameters:
- N, 8, operand and result width in bits; legal range N >= 2.

Ports:
- CLK  input  1  single clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- IN_VALID  input  1  operands and mode present.
- IN_READY  output  1  block can accept operands.
- A_IN  input  N  operand A.
- B_IN  input  N  operand B.
- CIN  input  1  carry-in for add; ignored for subtract.
- SUB  input  1  0 = A+B+CIN; 1 = A-B.
- FA_A  output  1  bit to full-adder A.
- FA_B  output  1  bit to full-adder B.
- FA_C  output  1  carry to full-adder C.
- FA_SUM  input  1  full-adder Sum.
- FA_CARRY  input  1  full-adder Carry.
- OUT_VALID  output  1  result valid.
- OUT_READY  input  1  consumer accepts result.
- SUM_OUT  output  N  result.
- COUT  output  1  final carry; for SUB, 1 = no borrow.
- OVF  output  1  two's-complement overflow.

Behaviour:
- Reset (RST=1 at an edge):
  - State goes to IDLE and the bit counter clears.
  - IN_READY=1, OUT_VALID=0, SUM_OUT=0, COUT=0, OVF=0, FA_A/FA_B/FA_C=0.
  - Reset applies in any state, including mid-SHIFT or DONE. Any partial result is discarded and no OUT_VALID pulse is produced.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - IN_READY=1.
  - On IN_VALID & IN_READY: a_sr <= A_IN; b_sr <= SUB ? ~B_IN : B_IN; carry_reg <= SUB ? 1 : CIN; cnt <= 0; go to SHIFT.
- SHIFT:
  - IN_READY=0; IN_VALID is ignored.
  - Cell drives: FA_A=a_sr[0], FA_B=b_sr[0], FA_C=carry_reg. These come only from registers, so the cell sees a stable input for the whole cycle.
  - The clock period must exceed the cell's worst-case gate delay.
  - Each edge:
    - sum_sr <= {FA_SUM, sum_sr[N-1:1]}.
    - carry_reg <= FA_CARRY.
    - a_sr and b_sr shift right by 1.
    - cnt <= cnt+1.
  - Edge with cnt==N-1 (MSB): OVF <= carry_reg ^ FA_CARRY; COUT <= FA_CARRY; go to DONE.
- DONE:
  - OUT_VALID=1; SUM_OUT=sum_sr, COUT and OVF held stable.
  - On OUT_READY=1: go to IDLE and OUT_VALID drops the next cycle.
  - OUT_READY low: all outputs hold indefinitely.
- Latency: if operands are accepted at edge k, OUT_VALID is visible after edge k+N, i.e. exactly N cycles in SHIFT.
- Throughput: one operation per N+2 cycles minimum (accept, N shifts, handoff). There is no overlap between operations.
- FA_A/FA_B/FA_C are 0 in IDLE and DONE.
- SUM_OUT, COUT and OVF are registered. They keep the last result after leaving DONE until the next DONE or reset.
- Arithmetic wraps modulo 2^N; no saturation.
- The counter is ceil(log2(N)) bits wide and never exceeds N-1.
- OUT_VALID and IN_READY are never both 1.
- Simultaneous IN_VALID and OUT_READY in DONE: the result is handed off and IN_VALID is not accepted that cycle. The operand is accepted in IDLE on the next cycle if IN_VALID is still held.
- The bench provides a behavioural full-adder model on the FA_* ports.

Test Plan:
- ADD 3C+0F: A=8'h3C, B=8'h0F, CIN=0, SUB=0 -> SUM_OUT=8'h4B, COUT=0, OVF=0; OUT_VALID first high exactly 8 cycles after the accepting edge.
- Carry wrap: A=8'hFF, B=8'h01, CIN=0 -> SUM_OUT=8'h00, COUT=1, OVF=0. Also A=8'h7F, B=8'h01 -> SUM_OUT=8'h80, COUT=0, OVF=1.
- Subtract 05-07: A=8'h05, B=8'h07, SUB=1, CIN=1 (ignored) -> SUM_OUT=8'hFE, COUT=0, OVF=0. Also 8'h80-8'h01 -> 8'h7F, COUT=1, OVF=1.
- Backpressure: hold OUT_READY=0 for 5 cycles in DONE with IN_VALID=1 -> outputs stable, IN_READY=0, no new load. Raise OUT_READY -> IDLE next cycle, then the new operand loads.
- Reset mid-operation: assert RST for 1 cycle at cnt=3 -> next cycle IDLE, IN_READY=1, OUT_VALID=0, FA_*=0, SUM_OUT=0. A following 8'h01+8'h01 gives 8'h02.
- Bit-stream check: for A=8'hA5, B=8'h5A, CIN=1, record FA_A/FA_B/FA_C per cycle -> LSB-first bits of the operands. FA_C follows the prior FA_CARRY. Result 8'h00, COUT=1, OVF=0.
